konix_clk_ce_gen: RTL and testbench

Reset sequencer and clock-enable generator that sits directly downstream of the system PLL. It runs on the 88.671875 MHz system clock and takes the PLL lock indication. It holds the core in reset until lock has been stable, then releases it. It also produces the single-cycle clock-enable strobes (pixel 17.734375 MHz, CPU ~5.91 MHz) that every other Konix Multisystem block uses in place of derived clocks.

---
 rtl/konix_clk_pkg.sv | 32 +++
 rtl/bit_sync2.sv | 39 +++
 rtl/konix_clk_ce_gen.sv | 176 +++++++++++++++++
 tb/tb_konix_clk_ce_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/konix_clk_pkg.sv
// -----------------------------------------------------------------------------
// konix_clk_pkg
// Shared clocking definitions for the Konix Multisystem core: reset-sequencer
// state encoding, default sequencing/divider constants, the derived
// clock-enable rates that downstream blocks use for their own timing maths,
// and a small width helper for parameterised counters.
// -----------------------------------------------------------------------------
package konix_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,  // waiting for a stable PLL lock, core held in reset
    ST_HOLD = 2'd1,  // lock is good, enables running, reset still asserted
    ST_RUN  = 2'd2   // core released
  } clk_state_e;

  // Default sequencing and divider settings.
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int DEF_RESET_HOLD  = 64;
  localparam int DEF_PIX_DIV     = 5;
  localparam int DEF_CPU_DIV     = 15;

  // System clock from PLL outclk_0 and the enable rates derived from it.
  localparam int SYS_CLK_HZ = 88_671_875;
  localparam int PIX_CE_HZ  = SYS_CLK_HZ / DEF_PIX_DIV;  // 17_734_375
  localparam int CPU_CE_HZ  = SYS_CLK_HZ / DEF_CPU_DIV;  // ~5_911_458

  // Bits needed for a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : konix_clk_pkg

// File: rtl/bit_sync2.sv
// -----------------------------------------------------------------------------
// bit_sync2
// Generic two-flop synchroniser for a single asynchronous level, with a
// synchronous clear that empties both stages. Used for the PLL lock input
// and for the joystick/host inputs elsewhere in the core.
//
// Ports:
//   clk  in   destination clock
//   clr  in   synchronous clear, active-high; forces both stages to 0
//   d    in   asynchronous input level
//   q    out  synchronised level, two clk edges after d is captured
// -----------------------------------------------------------------------------
module bit_sync2 (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // NOTE: state is only ever updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule : bit_sync2

// File: rtl/konix_clk_ce_gen.sv
// -----------------------------------------------------------------------------
// konix_clk_ce_gen
// Reset sequencer and clock-enable generator directly downstream of the
// system PLL. Holds the core in reset until PLL lock has been stable for
// LOCK_CYCLES cycles, runs the enables for RESET_HOLD more cycles with reset
// still asserted, then releases the core. Any loss of lock drops back to
// WAIT and is counted. All other blocks use ce_pix / ce_cpu instead of
// derived clocks.
//
// Ports:
//   clk            in   88.671875 MHz system clock
//   rst            in   synchronous active-high reset
//   pll_locked     in   PLL lock, asynchronous to clk
//   sys_reset      out  core reset, active-high, registered
//   ready          out  high only in RUN, registered
//   ce_pix         out  one-cycle pixel enable strobe (clk / PIX_DIV)
//   ce_cpu         out  one-cycle CPU enable strobe (clk / CPU_DIV)
//   lock_loss_cnt  out  saturating count of lock drops after first leaving WAIT
// -----------------------------------------------------------------------------
module konix_clk_ce_gen
  import konix_clk_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int RESET_HOLD  = DEF_RESET_HOLD,
  parameter int PIX_DIV     = DEF_PIX_DIV,
  parameter int CPU_DIV     = DEF_CPU_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       sys_reset,
  output logic       ready,
  output logic       ce_pix,
  output logic       ce_cpu,
  output logic [7:0] lock_loss_cnt
);

  // ce_cpu must land on a ce_pix edge, which only holds for whole multiples.
  if ((PIX_DIV < 1) || (CPU_DIV % PIX_DIV != 0)) begin : g_bad_div
    $error("konix_clk_ce_gen: CPU_DIV must be a positive integer multiple of PIX_DIV");
  end

  localparam int SW = cnt_w(LOCK_CYCLES);
  localparam int HW = cnt_w(RESET_HOLD);
  localparam int PW = cnt_w(PIX_DIV);
  localparam int CW = cnt_w(CPU_DIV);

  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(RESET_HOLD - 1);
  localparam logic [PW-1:0] PIX_LAST    = PW'(PIX_DIV - 1);
  localparam logic [CW-1:0] CPU_LAST    = CW'(CPU_DIV - 1);

  logic locked_s;

  clk_state_e    state_q, state_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [CW-1:0] cpu_cnt_q, cpu_cnt_d;
  logic [7:0]    lock_loss_cnt_q, lock_loss_cnt_d;
  logic          sys_reset_q, sys_reset_d;
  logic          ready_q, ready_d;
  logic          ce_pix_q, ce_pix_d;
  logic          ce_cpu_q, ce_cpu_d;
  logic          loss_inc;
  logic          div_run;

  bit_sync2 u_lock_sync (
    .clk (clk),
    .clr (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Sequencer: next state plus the WAIT/HOLD counters.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    stable_cnt_d = '0;
    hold_cnt_d   = '0;
    loss_inc     = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (locked_s) begin
          if (stable_cnt_q == STABLE_LAST) begin
            state_d = ST_HOLD;
          end else begin
            stable_cnt_d = stable_cnt_q + SW'(1);
          end
        end
      end
      // Lock loss is tested first so it beats a same-cycle HOLD->RUN.
      ST_HOLD: begin
        if (!locked_s) begin
          state_d  = ST_WAIT;
          loss_inc = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d  = ST_WAIT;
          loss_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  // Dividers and registered outputs. Outputs are computed from the next state
  // so they change on the same edge as the state itself.
  always_comb begin
    // Dividers sit at 0 through WAIT, so HOLD entry always restarts both in
    // phase; leaving for WAIT also zeroes them.
    div_run = (state_q != ST_WAIT) && (state_d != ST_WAIT);

    pix_cnt_d = '0;
    cpu_cnt_d = '0;
    if (div_run) begin
      pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PW'(1);
      cpu_cnt_d = (cpu_cnt_q == CPU_LAST) ? '0 : cpu_cnt_q + CW'(1);
    end

    // A strobe due on the edge that drops to WAIT is suppressed by div_run.
    ce_pix_d = div_run && (pix_cnt_q == PIX_LAST);
    ce_cpu_d = div_run && (cpu_cnt_q == CPU_LAST);

    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);

    lock_loss_cnt_d = lock_loss_cnt_q;
    if (loss_inc && (lock_loss_cnt_q != 8'hFF)) begin
      lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_WAIT;
      stable_cnt_q    <= '0;
      hold_cnt_q      <= '0;
      pix_cnt_q       <= '0;
      cpu_cnt_q       <= '0;
      lock_loss_cnt_q <= 8'd0;
      sys_reset_q     <= 1'b1;
      ready_q         <= 1'b0;
      ce_pix_q        <= 1'b0;
      ce_cpu_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      stable_cnt_q    <= stable_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      pix_cnt_q       <= pix_cnt_d;
      cpu_cnt_q       <= cpu_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
      sys_reset_q     <= sys_reset_d;
      ready_q         <= ready_d;
      ce_pix_q        <= ce_pix_d;
      ce_cpu_q        <= ce_cpu_d;
    end
  end

  assign sys_reset     = sys_reset_q;
  assign ready         = ready_q;
  assign ce_pix        = ce_pix_q;
  assign ce_cpu        = ce_cpu_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule : konix_clk_ce_gen

// File: tb/tb_konix_clk_ce_gen.sv
// -----------------------------------------------------------------------------
// tb_konix_clk_ce_gen
// Directed bench for konix_clk_ce_gen with LOCK_CYCLES=16, RESET_HOLD=4 and
// the default dividers (5 / 15). Edges are numbered by edge_n; outputs are
// sampled 1 time unit after each rising edge, and pll_locked changes at that
// same point, so "pll_locked set after edge r" means it is first captured at
// edge r+1. From such a rise HOLD starts at r+18 and RUN at r+22.
//
// Expected output vector {sys_reset, ready, ce_pix, ce_cpu} at edge e for a
// HOLD entry at edge h (d = e - h):
//   d < 4  : sys_reset=1, ready=0
//   d >= 4 : sys_reset=0, ready=1
//   ce_pix when d >= 5 and d % 5 == 0, ce_cpu when d >= 15 and d % 15 == 0
// -----------------------------------------------------------------------------
module tb_konix_clk_ce_gen;

  localparam int NEVER = 1_000_000;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       sys_reset;
  logic       ready;
  logic       ce_pix;
  logic       ce_cpu;
  logic [7:0] lock_loss_cnt;

  int n_tests;
  int n_fail;
  int edge_n;

  konix_clk_ce_gen #(
    .LOCK_CYCLES (16),
    .RESET_HOLD  (4),
    .PIX_DIV     (5),
    .CPU_DIV     (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .sys_reset     (sys_reset),
    .ready         (ready),
    .ce_pix        (ce_pix),
    .ce_cpu        (ce_cpu),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  function automatic logic [3:0] outs();
    return {sys_reset, ready, ce_pix, ce_cpu};
  endfunction

  function automatic logic [3:0] model(input int e, input int h);
    int d;
    d = e - h;
    if (d < 0) return 4'b1000;
    return {d < 4, d >= 4, (d >= 5) && (d % 5 == 0), (d >= 15) && (d % 15 == 0)};
  endfunction

  // Step n edges, comparing the output vector with the model at each one.
  task automatic track(input string tag, input int n, input int h);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, 32'(outs()), 32'(model(edge_n, h)));
    end
  endtask

  // One reset edge with lock low; that edge becomes edge 0.
  task automatic do_reset(input string tag);
    rst        = 1'b1;
    pll_locked = 1'b0;
    step();
    edge_n = 0;
    check({tag, "_outs"}, 32'(outs()), 32'h8);
    check({tag, "_loss"}, 32'(lock_loss_cnt), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r;
    int h;
    n_tests    = 0;
    n_fail     = 0;
    edge_n     = 0;
    rst        = 1'b1;
    pll_locked = 1'b0;

    // Steady lock from edge 0: release at 22, ce_pix from 23, ce_cpu from 33.
    step();
    do_reset("steady_rst");
    pll_locked = 1'b1;
    track("steady", 60, 18);

    // Late lock: 100 cycles low, then 22-cycle release from the rise.
    do_reset("late_rst");
    track("late_wait", 100, NEVER);
    pll_locked = 1'b1;
    r = edge_n;
    track("late_seq", 40, r + 18);
    check("late_loss", 32'(lock_loss_cnt), 32'd0);

    // Chattering lock: 10 high / 1 low five times never reaches HOLD.
    do_reset("chat_rst");
    for (int c = 0; c < 5; c++) begin
      pll_locked = 1'b1;
      track("chat_wait", 10, NEVER);
      pll_locked = 1'b0;
      track("chat_wait", 1, NEVER);
    end
    pll_locked = 1'b1;
    r = edge_n;
    h = r + 18;
    track("chat_seq", 40, h);
    check("chat_loss", 32'(lock_loss_cnt), 32'd0);

    // Loss in RUN at k = h+27: both strobes due at k+3 must be suppressed.
    track("run_pre", h + 27 - edge_n, h);
    pll_locked = 1'b0;
    track("run_loss_k12", 2, h);
    track("run_loss_wait", 6, NEVER);
    check("run_loss_cnt", 32'(lock_loss_cnt), 32'd1);
    pll_locked = 1'b1;
    r = edge_n;
    track("run_reseq", 50, r + 18);

    // Loss two cycles into HOLD, repeated 300 times; count saturates at 255.
    do_reset("sat_rst");
    pll_locked = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat (3) step();
      if (i < 3 || i == 254 || i == 255 || i == 299) begin
        check($sformatf("sat_cnt_i%0d", i), 32'(lock_loss_cnt), (i > 255) ? 32'd255 : 32'(i));
        check($sformatf("sat_outs_i%0d", i), 32'(outs()), 32'h8);
      end
      repeat (14) step();
      pll_locked = 1'b0;
      step();
      pll_locked = 1'b1;
    end
    r = edge_n;
    h = r + 18;
    repeat (3) step();
    check("sat_final", 32'(lock_loss_cnt), 32'd255);

    // rst mid-RUN on an edge where both strobes are due: rst wins.
    track("mid_pre", h + 14 - edge_n, h);
    rst = 1'b1;
    step();
    check("mid_rst_outs", 32'(outs()), 32'h8);
    check("mid_rst_loss", 32'(lock_loss_cnt), 32'd0);
    rst = 1'b0;
    r = edge_n;
    track("mid_reseq", 40, r + 18);
    check("mid_reseq_loss", 32'(lock_loss_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_konix_clk_ce_gen
